// File: rtl/uart_cmd_pkg.sv
// Shared types and ASCII constants for the UART command decoder.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_D1,
        WAIT_D2,
        WAIT_CR,
        RESP
    } state_t;

    localparam logic [7:0] ACK  = 8'h21;
    localparam logic [7:0] NAK  = 8'h3F;
    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_C = 8'h43;
    localparam logic [7:0] CH_M = 8'h4D;
    localparam logic [7:0] CH_S = 8'h53;

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Inter-byte idle counter; expired flags TIMEOUT_CYC-1 idle cycles since clear.
module cmd_timeout_counter #(
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    assign expired = enable & (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// RX-FIFO byte stream command decoder: command pulses plus one
// acknowledge byte per command into the TX FIFO.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rx_rd,
    input  logic       tx_full,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    output logic       cmd_run,
    output logic       cmd_clear,
    output logic       cmd_mode,
    output logic       set_valid,
    output logic [6:0] set_value,
    output logic [7:0] err_cnt
);

    state_t     state;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [7:0] ch;
    logic       waiting;
    logic       expired;
    logic       bad;

    assign ch      = to_upper(rx_data);
    assign waiting = (state == WAIT_D1) || (state == WAIT_D2) ||
                     (state == WAIT_CR);
    assign rx_rd   = ~rst & (state != RESP) & ~rx_empty;
    assign tx_wr   = ~rst & (state == RESP) & ~tx_full;

    cmd_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_rd | ~waiting),
        .enable (waiting),
        .expired(expired)
    );

    // Any rejected byte or a stalled multi-byte command ends in a NAK.
    always_comb begin
        bad = 1'b0;
        unique case (state)
            IDLE:
                bad = rx_rd &
                      !(ch inside {CH_R, CH_C, CH_M, CH_S, CR, LF});
            WAIT_D1, WAIT_D2:
                bad = rx_rd ? !is_digit(rx_data) : expired;
            WAIT_CR:
                bad = rx_rd ? (rx_data != CR) : expired;
            default:
                bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            d1        <= '0;
            d2        <= '0;
            tx_data   <= '0;
            cmd_run   <= 1'b0;
            cmd_clear <= 1'b0;
            cmd_mode  <= 1'b0;
            set_valid <= 1'b0;
            set_value <= '0;
            err_cnt   <= '0;
        end else begin
            cmd_run   <= 1'b0;
            cmd_clear <= 1'b0;
            cmd_mode  <= 1'b0;
            set_valid <= 1'b0;
            if (bad) begin
                tx_data <= NAK;
                err_cnt <= sat_inc(err_cnt);
                state   <= RESP;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (rx_rd) begin
                            unique case (1'b1)
                                ch == CH_R: begin
                                    cmd_run <= 1'b1;
                                    tx_data <= ACK;
                                    state   <= RESP;
                                end
                                ch == CH_C: begin
                                    cmd_clear <= 1'b1;
                                    tx_data   <= ACK;
                                    state     <= RESP;
                                end
                                ch == CH_M: begin
                                    cmd_mode <= 1'b1;
                                    tx_data  <= ACK;
                                    state    <= RESP;
                                end
                                ch == CH_S: state <= WAIT_D1;
                                default: state <= IDLE;
                            endcase
                        end
                    end
                    WAIT_D1: begin
                        if (rx_rd) begin
                            d1    <= rx_data[3:0];
                            state <= WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        if (rx_rd) begin
                            d2    <= rx_data[3:0];
                            state <= WAIT_CR;
                        end
                    end
                    WAIT_CR: begin
                        if (rx_rd) begin
                            set_value <= 7'(d1) * 7'd10 + 7'(d2);
                            set_valid <= 1'b1;
                            tx_data   <= ACK;
                            state     <= RESP;
                        end
                    end
                    RESP: begin
                        if (!tx_full) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench: directed and random byte streams against a
// token-level reference parser of the command language.
module tb_uart_cmd_decoder;

    typedef logic [7:0] bq_t[$];

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       tx_full = 1'b0;
    logic       rx_rd;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       cmd_run;
    logic       cmd_clear;
    logic       cmd_mode;
    logic       set_valid;
    logic [6:0] set_value;
    logic [7:0] err_cnt;

    uart_cmd_decoder #(.TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_empty (rx_empty),
        .rx_data  (rx_data),
        .rx_rd    (rx_rd),
        .tx_full  (tx_full),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .cmd_run  (cmd_run),
        .cmd_clear(cmd_clear),
        .cmd_mode (cmd_mode),
        .set_valid(set_valid),
        .set_value(set_value),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_pop = 0;
    int   last_push = 0;
    bit   pend = 1'b0;
    bq_t  rxq;
    bq_t  obs_tx;
    bq_t  exp_tx;
    logic [15:0] obs_ev[$];
    logic [15:0] exp_ev[$];
    int   exp_err = 0;
    int   exp_set = 0;
    logic [7:0] letters[6] = '{8'h52, 8'h43, 8'h4D, 8'h72, 8'h63, 8'h6D};

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // RX FIFO model and output monitor.
    always @(negedge clk) begin
        if (pend) void'(rxq.pop_front());
        rx_empty = (rxq.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rxq[0];
        #3;
        cyc++;
        pend = rx_rd;
        if (rx_rd) begin
            chk("rd_when_empty", int'(rx_empty), 0);
            last_pop = cyc;
        end
        if (tx_wr) begin
            chk("wr_when_full", int'(tx_full), 0);
            obs_tx.push_back(tx_data);
            last_push = cyc;
        end
        if (cmd_run || cmd_clear || cmd_mode || set_valid) begin
            chk("pulse_latency", cyc - last_pop, 1);
            chk("pulse_onehot", int'(cmd_run) + int'(cmd_clear) +
                int'(cmd_mode) + int'(set_valid), 1);
            if (cmd_run)   obs_ev.push_back({8'h52, 8'h00});
            if (cmd_clear) obs_ev.push_back({8'h43, 8'h00});
            if (cmd_mode)  obs_ev.push_back({8'h4D, 8'h00});
            if (set_valid) obs_ev.push_back({8'h53, 1'b0, set_value});
        end
    end

    function automatic logic [7:0] up(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'd32 : b;
    endfunction

    function automatic bit good(input int k, input logic [7:0] b);
        if (k < 2) return (b >= 8'h30 && b <= 8'h39);
        return (b == 8'h0D);
    endfunction

    function automatic bq_t q_of(input string t);
        bq_t q;
        for (int i = 0; i < t.len(); i++) q.push_back(t[i]);
        return q;
    endfunction

    task automatic nak();
        exp_tx.push_back(8'h3F);
        if (exp_err < 255) exp_err++;
    endtask

    // Token parser: a set command needs digit, digit, CR; the first
    // wrong byte is swallowed, and a stream ending early times out.
    task automatic model(input bq_t s);
        int i;
        int k;
        logic [7:0] u;
        i = 0;
        while (i < s.size()) begin
            u = up(s[i]);
            i++;
            if (u == 8'h52 || u == 8'h43 || u == 8'h4D) begin
                exp_ev.push_back({u, 8'h00});
                exp_tx.push_back(8'h21);
            end else if (u == 8'h53) begin
                k = 0;
                while (k < 3 && i < s.size() && good(k, s[i])) begin
                    k++;
                    i++;
                end
                if (k == 3) begin
                    exp_set = 10 * (int'(s[i-3]) - 48) + (int'(s[i-2]) - 48);
                    exp_ev.push_back({8'h53, 8'(exp_set)});
                    exp_tx.push_back(8'h21);
                end else begin
                    if (i < s.size()) i++;
                    nak();
                end
            end else if (u != 8'h0D && u != 8'h0A) begin
                nak();
            end
        end
    endtask

    task automatic cycles(input int n, input int mode);
        repeat (n) begin
            @(negedge clk);
            #2;
            tx_full = (mode == 2) ? 1'b1 :
                      (mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    endtask

    task automatic clear_q();
        obs_tx.delete();
        obs_ev.delete();
        exp_tx.delete();
        exp_ev.delete();
    endtask

    task automatic compare(input string tag);
        chk({tag, "_tx_n"}, obs_tx.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
            chk({tag, "_tx"}, int'(obs_tx[i]), int'(exp_tx[i]));
        chk({tag, "_ev_n"}, obs_ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++)
            chk({tag, "_ev"}, int'(obs_ev[i]), int'(exp_ev[i]));
        chk({tag, "_err"}, int'(err_cnt), exp_err);
        chk({tag, "_setval"}, int'(set_value), exp_set);
        chk({tag, "_rx_left"}, rxq.size(), 0);
    endtask

    task automatic run_chk(input bq_t s, input int mode, input string tag);
        clear_q();
        model(s);
        foreach (s[i]) rxq.push_back(s[i]);
        cycles(8 * s.size() + 30, mode);
        tx_full = 1'b0;
        cycles(10, 0);
        compare(tag);
    endtask

    task automatic gen(output bq_t s);
        int v;
        int p;
        logic [7:0] b;
        s.delete();
        repeat ($urandom_range(2, 6)) begin
            case ($urandom_range(0, 4))
                0: s.push_back(letters[$urandom_range(0, 5)]);
                1: begin
                    v = $urandom_range(0, 99);
                    s.push_back($urandom_range(0, 1) ? 8'h53 : 8'h73);
                    s.push_back(8'(48 + v / 10));
                    s.push_back(8'(48 + v % 10));
                    s.push_back(8'h0D);
                end
                2: s.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
                3: begin
                    do b = 8'($urandom); while (up(b) == 8'h53);
                    s.push_back(b);
                end
                default: begin
                    p = $urandom_range(0, 2);
                    s.push_back(8'h53);
                    for (int i = 0; i < p; i++)
                        s.push_back(8'(48 + $urandom_range(0, 9)));
                    s.push_back(8'($urandom_range(8'h3A, 8'h40)));
                end
            endcase
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rx_rd"}, int'(rx_rd), 0);
        chk({tag, "_tx_wr"}, int'(tx_wr), 0);
        chk({tag, "_tx_data"}, int'(tx_data), 0);
        chk({tag, "_pulses"}, int'({cmd_run, cmd_clear, cmd_mode, set_valid}), 0);
        chk({tag, "_setval"}, int'(set_value), 0);
        chk({tag, "_err"}, int'(err_cnt), 0);
    endtask

    initial begin
        bq_t s;
        int d;

        rst = 1'b1;
        cycles(3, 0);
        chk_reset("por");
        rst = 1'b0;
        cycles(2, 0);

        run_chk(q_of("R"), 0, "run");
        chk("run_push_lat", last_push - last_pop, 1);
        run_chk(q_of("S42\015"), 0, "set42");
        run_chk(q_of("s99\015"), 0, "set99");
        run_chk(q_of("S4xC"), 0, "bad_set");

        clear_q();
        s = q_of("S1");
        model(s);
        foreach (s[i]) rxq.push_back(s[i]);
        cycles(45, 0);
        compare("timeout");
        d = last_push - last_pop;
        chk("timeout_delay", int'(d == TO || d == TO + 1), 1);
        run_chk(q_of("5\015"), 0, "late");

        clear_q();
        s = q_of("MR");
        model(s);
        tx_full = 1'b1;
        foreach (s[i]) rxq.push_back(s[i]);
        cycles(12, 2);
        chk("stall_ev_n", obs_ev.size(), 1);
        if (obs_ev.size() > 0) chk("stall_ev", int'(obs_ev[0]), int'({8'h4D, 8'h00}));
        chk("stall_tx_n", obs_tx.size(), 0);
        chk("stall_rx_left", rxq.size(), 1);
        tx_full = 1'b0;
        cycles(12, 0);
        compare("stall");

        s.delete();
        repeat (260) s.push_back(8'h23);
        run_chk(s, 0, "saturate");

        repeat (25) begin
            gen(s);
            run_chk(s, 1, "rand");
        end

        clear_q();
        s = q_of("S7");
        foreach (s[i]) rxq.push_back(s[i]);
        cycles(3, 0);
        rst = 1'b1;
        cycles(2, 0);
        chk_reset("mid_rst");
        rst = 1'b0;
        exp_err = 0;
        exp_set = 0;
        cycles(25, 0);
        chk("mid_rst_tx_n", obs_tx.size(), 0);
        chk("mid_rst_ev_n", obs_ev.size(), 0);
        run_chk(q_of("c"), 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
